// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF/ID instruction queue.
// Optional zero-latency bypass is enabled by defining IF_ID_QUEUE_BYPASS_EN.
package if_id_queue_pkg;

    localparam int          INSTR_W       = 32;
    localparam int          PC_W          = 32;
    localparam int          DEFAULT_DEPTH = 4;
    localparam logic [31:0] NOP           = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/if_id_queue_queue_storage.sv
// Register array for queued {instr, pc} pairs: one synchronous write port,
// one asynchronous read port.
module queue_storage #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; the pointers and count qualify every read,
    // so stale contents are never observable and the array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Elastic FIFO between fetch and decode with flush on redirect.
// Define IF_ID_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pcplus4,
    input  logic               out_ready,
    output logic [AW:0]        count
);

    if (AW != $clog2(DEPTH) || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("if_id_queue: DEPTH must be a power of 2 in 2..16 and AW must equal log2(DEPTH)");
    end

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic   w_empty;
    logic   w_full;
    logic   w_bypass;
    logic   w_push;
    logic   w_pop;
    logic   w_take;
    logic   w_wr;
    logic   w_rd;
    entry_t w_wr_data;
    entry_t w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = ~w_full;
    assign out_valid = (~w_empty & ~flush) | w_bypass;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready;

    // A bypassed pair taken by decode in the same cycle never touches storage.
    assign w_take = w_bypass & out_ready;
    assign w_wr   = w_push & ~w_take;
    assign w_rd   = w_pop & ~w_take;

    assign w_wr_data.instr = in_instr;
    assign w_wr_data.pc    = in_pc;

    queue_storage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        out_instr = NOP;
        out_pc    = '0;
        if (w_bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (!w_empty) begin
            out_instr = w_rd_data.instr;
            out_pc    = w_rd_data.pc;
        end
    end

    assign out_pcplus4 = out_pc + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Elastic instruction buffer between the fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Stores {instruction, PC} pairs from fetch and presents the oldest pair to decode under a valid/ready handshake.
- Decouples fetch from decode stalls; flushes on redirect (branch/jump resolved in decode).
- Ordering is strict FIFO.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, range 2..16.
- AW, 2, pointer width, log2(DEPTH); consistency is checked in simulation.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  fetch presents a valid pair
- in_instr  input  32  fetched instruction
- in_pc  input  32  PC of in_instr
- in_ready  output  1  queue can accept a pair this cycle
- flush  input  1  discard all stored and incoming pairs
- out_valid  output  1  head entry valid for decode
- out_instr  output  32  head instruction
- out_pc  output  32  head PC
- out_pcplus4  output  32  out_pc + 4, modulo 2^32
- out_ready  input  1  decode consumes head this cycle
- count  output  AW+1  occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out_instr=0, out_pc=0, out_pcplus4=4, in_ready=1. Storage contents are don't-care.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is independent of out_ready, so there is no combinational ready path from decode to fetch. A push and a pop in the same cycle at full is not allowed.
- out_valid = (count != 0) & !flush.
- When count==0, out_instr=0 (NOP), out_pc=0 and out_pcplus4=4. Otherwise they show the entry at rd_ptr (combinational read of registered storage).
- Latency: a pair pushed at edge k is visible on out_* in cycle k+1 (1 cycle minimum).
- Count update: push only, +1; pop only, -1; push and pop together, unchanged. Pointers wrap modulo DEPTH.
- Flush at edge: count=0 and rd_ptr=wr_ptr=0. A push and a pop requested in the same cycle are both ignored. Flush has priority over everything except reset.
- Full (count==DEPTH): in_ready=0, and in_valid is ignored. Fetch must hold the PC (drives PC_WrEn low).
- Empty: out_valid=0, and out_ready is ignored.
- Reset mid-operation: all entries are discarded immediately, regardless of handshakes in flight.
- No X propagation: outputs are defined in every state after reset.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined: when count==0 and in_valid and !flush, out_valid=1 and out_* show in_* combinationally (zero-latency bypass). If out_ready is also 1, the pair is consumed directly and not written; count stays 0. If out_ready is 0, the pair is written normally.
- Undefined: no bypass; minimum latency is 1 cycle, exactly as in Behaviour.

Decomposition:
- Shared package/header:
  - NOP constant 32'h00000000.
  - Default DEPTH.
  - Width constants for instruction and PC (32).
- Sub-module queue_storage:
  - DEPTH x 64-bit register array.
  - One synchronous write port (wr_en, wr_addr, wr_data) and one asynchronous read port.
  - No reset on the array.
- Top level holds pointers, count, handshake and flush/bypass logic.

Test Plan:
- Reset then idle: assert reset mid-cycle -> out_valid=0, count=0, in_ready=1, out_pcplus4=32'h4 immediately, before the next edge.
- Fill and drain in order: push PCs 0x3000, 0x3004, 0x3008, 0x300C with out_ready=0 -> count=4, in_ready=0; a fifth push (0x3010) is ignored. Then out_ready=1 for 4 cycles -> out_pc sequence 0x3000..0x300C, then out_valid=0.
- Simultaneous push/pop at count=2: push 0x3010 while popping -> count stays 2, head advances. Wrap-around verified over 3*DEPTH continuous transfers with no gaps and no reordering.
- Flush with push and pop pending: count=3, in_valid=1, out_ready=1, flush=1 -> out_valid=0 during the flush cycle, count=0 next cycle, and the pushed pair never appears.
- Decode stall: out_ready=0 for 5 cycles with count=1 -> out_instr and out_pc stable, count=1. Release -> exactly one pop.
- Bypass (macro defined): empty queue, in_valid=1, in_pc=0x3000, out_ready=1 -> same-cycle out_valid=1, out_pc=0x3000, count stays 0. Macro undefined -> out_valid rises the cycle after.
